// File: rtl/stack_pointer_unit_pkg.sv
// stack_pointer_unit_pkg
// Shared constants and the per-stack operation encoding used by the stack
// pointer unit and its per-stack counter.
package stack_pointer_unit_pkg;

    localparam logic [15:0] MS_BASE_DEF  = 16'h07FF;
    localparam logic [15:0] RS_BASE_DEF  = 16'h0FFF;
    localparam int          MS_DEPTH_DEF = 256;
    localparam int          RS_DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_PUSH   = 2'd1,
        OP_POP    = 2'd2,
        OP_RELOAD = 2'd3
    } stack_op_e;

    // RegReset wins over Write; Pop only means something when Write is set.
    function automatic stack_op_e decode_op(input logic wr, input logic pop, input logic rr);
        if (rr)  return OP_RELOAD;
        if (!wr) return OP_HOLD;
        return pop ? OP_POP : OP_PUSH;
    endfunction

endpackage

// File: rtl/stack_pointer_unit_ctr.sv
// stack_ptr_ctr
// Pointer, depth and sticky overflow/underflow for one downward-growing stack.
// Config macro: JALA_STACK_GUARD_EN (full/empty guarding + fault flags).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_op              decoded stack operation (HOLD/PUSH/POP/RELOAD)
//   i_err_clr         clear sticky flags (a fault raised this cycle survives)
//   o_ptr / o_top     free-slot pointer / pointer+1 (top element)
//   o_depth           entry count
//   o_ovf / o_udf     sticky overflow / underflow
module stack_ptr_ctr
    import stack_pointer_unit_pkg::*;
#(
    parameter logic [15:0] BASE  = MS_BASE_DEF,
    parameter int          DEPTH = MS_DEPTH_DEF,
    localparam int         DW    = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  stack_op_e       i_op,
    input  logic            i_err_clr,
    output logic [15:0]     o_ptr,
    output logic [15:0]     o_top,
    output logic [DW-1:0]   o_depth,
    output logic            o_ovf,
    output logic            o_udf
);

    logic [15:0]   r_ptr;
    logic [DW-1:0] r_depth;
    logic [15:0]   w_ptr_nxt;
    logic [DW-1:0] w_depth_nxt;
    logic          w_full;
    logic          w_empty;

`ifdef JALA_STACK_GUARD_EN
    logic r_ovf;
    logic r_udf;
    logic w_ovf_set;
    logic w_udf_set;

    assign w_full    = (r_depth == DW'(DEPTH));
    assign w_empty   = (r_depth == '0);
    assign w_ovf_set = (i_op == OP_PUSH) && w_full;
    assign w_udf_set = (i_op == OP_POP)  && w_empty;

    // RELOAD leaves the flags alone; only CtrlRst or ErrClear clear them,
    // and a fault raised in the ErrClear cycle wins for that flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~i_err_clr);
            r_udf <= w_udf_set | (r_udf & ~i_err_clr);
        end
    end

    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
`else
    // Unguarded: pointer and depth simply wrap; flags are constant zero.
    logic w_unused_err_clr;
    assign w_unused_err_clr = i_err_clr;
    assign w_full  = 1'b0;
    assign w_empty = 1'b0;
    assign o_ovf   = 1'b0;
    assign o_udf   = 1'b0;
`endif

    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_depth_nxt = r_depth;
        case (i_op)
            OP_RELOAD: begin
                w_ptr_nxt   = BASE;
                w_depth_nxt = '0;
            end
            OP_PUSH: if (!w_full) begin
                w_ptr_nxt   = r_ptr - 16'd1;
                w_depth_nxt = r_depth + DW'(1);
            end
            OP_POP: if (!w_empty) begin
                w_ptr_nxt   = r_ptr + 16'd1;
                w_depth_nxt = r_depth - DW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= BASE;
            r_depth <= '0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_depth <= w_depth_nxt;
        end
    end

    assign o_ptr   = r_ptr;
    assign o_top   = r_ptr + 16'd1;
    assign o_depth = r_depth;

endmodule

// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit
// Main-stack and return-stack pointers feeding push/pop addresses to the
// memory stage. Push writes at *POut, pop reads at *PTop, both pre-update.
// Config macro: JALA_STACK_GUARD_EN (depth guarding and sticky faults).
// Ports:
//   CLK, CtrlRst                          clock, synchronous active-high reset
//   MSPop/MSPWrite/MSPRegReset            main-stack control
//   RSPop/RSPWrite/RSPRegReset            return-stack control
//   ErrClear                              clear sticky faults
//   MSPOut/MSPTop, RSPOut/RSPTop          pointers and pointer+1
//   MSDepth, RSDepth                      entry counts
//   MSOverflow/MSUnderflow/RSOverflow/RSUnderflow, StackFault
module stack_pointer_unit
    import stack_pointer_unit_pkg::*;
#(
    parameter logic [15:0] MS_BASE  = MS_BASE_DEF,
    parameter logic [15:0] RS_BASE  = RS_BASE_DEF,
    parameter int          MS_DEPTH = MS_DEPTH_DEF,
    parameter int          RS_DEPTH = RS_DEPTH_DEF
) (
    input  logic                          CLK,
    input  logic                          CtrlRst,
    input  logic                          MSPop,
    input  logic                          MSPWrite,
    input  logic                          MSPRegReset,
    input  logic                          RSPop,
    input  logic                          RSPWrite,
    input  logic                          RSPRegReset,
    input  logic                          ErrClear,
    output logic [15:0]                   MSPOut,
    output logic [15:0]                   MSPTop,
    output logic [15:0]                   RSPOut,
    output logic [15:0]                   RSPTop,
    output logic [$clog2(MS_DEPTH+1)-1:0] MSDepth,
    output logic [$clog2(RS_DEPTH+1)-1:0] RSDepth,
    output logic                          MSOverflow,
    output logic                          MSUnderflow,
    output logic                          RSOverflow,
    output logic                          RSUnderflow,
    output logic                          StackFault
);

    stack_op_e w_ms_op;
    stack_op_e w_rs_op;

    assign w_ms_op = decode_op(MSPWrite, MSPop, MSPRegReset);
    assign w_rs_op = decode_op(RSPWrite, RSPop, RSPRegReset);

    stack_ptr_ctr #(.BASE(MS_BASE), .DEPTH(MS_DEPTH)) u_ms (
        .i_clk     (CLK),
        .i_rst     (CtrlRst),
        .i_op      (w_ms_op),
        .i_err_clr (ErrClear),
        .o_ptr     (MSPOut),
        .o_top     (MSPTop),
        .o_depth   (MSDepth),
        .o_ovf     (MSOverflow),
        .o_udf     (MSUnderflow)
    );

    stack_ptr_ctr #(.BASE(RS_BASE), .DEPTH(RS_DEPTH)) u_rs (
        .i_clk     (CLK),
        .i_rst     (CtrlRst),
        .i_op      (w_rs_op),
        .i_err_clr (ErrClear),
        .o_ptr     (RSPOut),
        .o_top     (RSPTop),
        .o_depth   (RSDepth),
        .o_ovf     (RSOverflow),
        .o_udf     (RSUnderflow)
    );

    assign StackFault = MSOverflow | MSUnderflow | RSOverflow | RSUnderflow;

endmodule
